// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI frame receiver slice.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  localparam int FRAME_CNT_W = 8;

  // Bit offset of word idx inside a packed multi-word frame.
  function automatic int word_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/spi_frame_receiver_if.sv
// Serial input and committed-frame output bundle of the SPI frame receiver.
interface spi_frame_receiver_if
  import spi_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 3
) ();

  logic                        cs_n;
  logic                        sdi;
  logic [NUM_WORDS*WORD_W-1:0] words_o;
  logic [NUM_WORDS-1:0]        led_o;
  logic                        frame_valid_o;
  logic [FRAME_CNT_W-1:0]      frame_cnt_o;
  logic                        short_err_o;
  logic                        overrun_err_o;

  modport master (
    output cs_n, sdi,
    input  words_o, led_o, frame_valid_o, frame_cnt_o, short_err_o, overrun_err_o
  );

  modport slave (
    input  cs_n, sdi,
    output words_o, led_o, frame_valid_o, frame_cnt_o, short_err_o, overrun_err_o
  );

endinterface

// File: rtl/spi_word_shifter.sv
// Deserialises one WORD_W-bit word; word_done flags the edge on which the last bit arrives.
module spi_word_shifter #(
  parameter int WORD_W    = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic              sclk,
  input  logic              resetn,
  input  logic              en,
  input  logic              clr,
  input  logic              sdi,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int BC_W = $clog2(WORD_W);

  logic [WORD_W-1:0] shreg_q;
  logic [BC_W-1:0]   bit_cnt_q;

  // word already includes the bit being sampled, so the top can store it on the same edge.
  always_comb begin
    word      = (MSB_FIRST != 0) ? {shreg_q[WORD_W-2:0], sdi} : {sdi, shreg_q[WORD_W-1:1]};
    word_done = en && (bit_cnt_q == BC_W'(WORD_W - 1));
  end

  always_ff @(posedge sclk) begin
    if (!resetn || clr) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if (en) begin
      shreg_q   <= word;
      bit_cnt_q <= word_done ? '0 : bit_cnt_q + BC_W'(1);
    end
  end

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI receive-only frame deserialiser: stages NUM_WORDS words and commits whole frames atomically.
module spi_frame_receiver
  import spi_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 3,
  parameter int MSB_FIRST = 1
) (
  input  logic                  sclk,
  input  logic                  resetn,
  spi_frame_receiver_if.slave   bus
);

  localparam int              FRAME_W   = NUM_WORDS * WORD_W;
  localparam int              WC_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_WORDS - 1);

  state_t                 state_q, state_d;
  logic                   shift_en, shift_clr, word_done;
  logic [WORD_W-1:0]      shift_word;
  logic                   commit, abort, overrun_hit;
  logic [WC_W-1:0]        word_cnt_q;
  logic [FRAME_W-1:0]     stage_q, words_q, commit_frame;
  logic                   frame_valid_q, short_err_q, overrun_err_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  spi_word_shifter #(
    .WORD_W   (WORD_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_shifter (
    .sclk     (sclk),
    .resetn   (resetn),
    .en       (shift_en),
    .clr      (shift_clr),
    .sdi      (bus.sdi),
    .word     (shift_word),
    .word_done(word_done)
  );

  always_ff @(posedge sclk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    shift_en    = 1'b0;
    shift_clr   = 1'b0;
    commit      = 1'b0;
    abort       = 1'b0;
    overrun_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.cs_n) begin
          shift_en = 1'b1;
          state_d  = RECV;
        end else begin
          shift_clr = 1'b1;
        end
      end
      RECV: begin
        if (bus.cs_n) begin
          abort     = 1'b1;
          shift_clr = 1'b1;
          state_d   = IDLE;
        end else begin
          shift_en = 1'b1;
          if (word_done && (word_cnt_q == LAST_WORD)) begin
            commit  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Bits clocked after a full frame are dropped and only flagged.
        shift_clr = 1'b1;
        if (bus.cs_n) state_d = IDLE;
        else          overrun_hit = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The final word bypasses staging so the committed frame appears one edge after its last bit.
  always_comb begin
    commit_frame = stage_q;
    commit_frame[word_lsb(NUM_WORDS - 1, WORD_W) +: WORD_W] = shift_word;
  end

  always_ff @(posedge sclk) begin
    if (!resetn) begin
      word_cnt_q    <= '0;
      stage_q       <= '0;
      words_q       <= '0;
      frame_cnt_q   <= '0;
      frame_valid_q <= 1'b0;
      short_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      if (abort || (state_q != RECV)) begin
        word_cnt_q <= '0;
        if (abort) stage_q <= '0;
      end else if (word_done) begin
        stage_q[word_lsb(int'(word_cnt_q), WORD_W) +: WORD_W] <= shift_word;
        word_cnt_q <= commit ? '0 : word_cnt_q + WC_W'(1);
      end
      if (commit) begin
        words_q       <= commit_frame;
        frame_cnt_q   <= frame_cnt_q + FRAME_CNT_W'(1);
        frame_valid_q <= 1'b1;
        short_err_q   <= 1'b0;
      end
      if (abort)       short_err_q   <= 1'b1;
      if (overrun_hit) overrun_err_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_led
    assign bus.led_o[k] = ~words_q[word_lsb(k, WORD_W) + WORD_W - 1];
  end

  assign bus.words_o       = words_q;
  assign bus.frame_valid_o = frame_valid_q;
  assign bus.frame_cnt_o   = frame_cnt_q;
  assign bus.short_err_o   = short_err_q;
  assign bus.overrun_err_o = overrun_err_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench: instance a is 16x3 MSB-first, instance b is 8x2 LSB-first.
module tb_spi_frame_receiver;

  logic sclk;
  logic resetn;
  int   checks;
  int   failures;

  spi_frame_receiver_if #(.WORD_W(16), .NUM_WORDS(3)) bus_a ();
  spi_frame_receiver_if #(.WORD_W(8),  .NUM_WORDS(2)) bus_b ();

  spi_frame_receiver #(.WORD_W(16), .NUM_WORDS(3), .MSB_FIRST(1)) dut_a (
    .sclk  (sclk),
    .resetn(resetn),
    .bus   (bus_a)
  );

  spi_frame_receiver #(.WORD_W(8), .NUM_WORDS(2), .MSB_FIRST(0)) dut_b (
    .sclk  (sclk),
    .resetn(resetn),
    .bus   (bus_b)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  // Drives one sclk edge on the selected instance; returns at the following negedge.
  task automatic applyStimulus(input bit sel_b, input logic cs, input logic d);
    if (sel_b) begin
      bus_b.cs_n = cs;
      bus_b.sdi  = d;
      bus_a.cs_n = 1'b1;
    end else begin
      bus_a.cs_n = cs;
      bus_a.sdi  = d;
      bus_b.cs_n = 1'b1;
    end
    @(negedge sclk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sendWordA(input logic [15:0] w, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) applyStimulus(1'b0, 1'b0, w[i]);
  endtask

  task automatic sendFrameA(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    sendWordA(w0, 16);
    sendWordA(w1, 16);
    sendWordA(w2, 16);
  endtask

  task automatic sendWordB(input logic [7:0] w);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, w[i]);
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_words"},   64'(bus_a.words_o),       64'h0);
    checkOutput({tag, "_led"},     64'(bus_a.led_o),         64'h7);
    checkOutput({tag, "_valid"},   64'(bus_a.frame_valid_o), 64'h0);
    checkOutput({tag, "_cnt"},     64'(bus_a.frame_cnt_o),   64'h0);
    checkOutput({tag, "_short"},   64'(bus_a.short_err_o),   64'h0);
    checkOutput({tag, "_overrun"}, 64'(bus_a.overrun_err_o), 64'h0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    resetn     = 1'b0;
    bus_a.cs_n = 1'b1;
    bus_a.sdi  = 1'b0;
    bus_b.cs_n = 1'b1;
    bus_b.sdi  = 1'b0;
    @(negedge sclk);

    // Test 1: reset values, then a clean MSB-first frame.
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    resetn = 1'b1;
    checkResetA("t1_reset");
    sendWordA(16'h1234, 16);
    sendWordA(16'h8001, 16);
    sendWordA(16'h7FFF, 15);
    checkOutput("t1_no_partial_words", 64'(bus_a.words_o),     64'h0);
    checkOutput("t1_no_partial_cnt",   64'(bus_a.frame_cnt_o), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_words_at_last_bit", 64'(bus_a.words_o), 64'h7FFF_8001_1234);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t1_words",   64'(bus_a.words_o),       64'h7FFF_8001_1234);
    checkOutput("t1_led",     64'(bus_a.led_o),         64'h5);
    checkOutput("t1_cnt",     64'(bus_a.frame_cnt_o),   64'h1);
    checkOutput("t1_valid",   64'(bus_a.frame_valid_o), 64'h1);
    checkOutput("t1_short",   64'(bus_a.short_err_o),   64'h0);
    checkOutput("t1_overrun", 64'(bus_a.overrun_err_o), 64'h0);

    // Test 2: short frame aborts, next full frame clears short_err.
    sendWordA(16'hAAAA, 16);
    sendWordA(16'h5555, 4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t2_short_set",     64'(bus_a.short_err_o), 64'h1);
    checkOutput("t2_words_kept",    64'(bus_a.words_o),     64'h7FFF_8001_1234);
    checkOutput("t2_cnt_kept",      64'(bus_a.frame_cnt_o), 64'h1);
    sendFrameA(16'h0001, 16'hFFFF, 16'h8000);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t2_words",         64'(bus_a.words_o),     64'h8000_FFFF_0001);
    checkOutput("t2_led",           64'(bus_a.led_o),       64'h1);
    checkOutput("t2_cnt",           64'(bus_a.frame_cnt_o), 64'h2);
    checkOutput("t2_short_cleared", 64'(bus_a.short_err_o), 64'h0);

    // Test 3: extra bits after a full frame raise overrun and are ignored.
    sendFrameA(16'h0F0F, 16'hF0F0, 16'h00FF);
    checkOutput("t3_words_commit", 64'(bus_a.words_o),       64'h00FF_F0F0_0F0F);
    checkOutput("t3_cnt",          64'(bus_a.frame_cnt_o),   64'h3);
    checkOutput("t3_no_overrun",   64'(bus_a.overrun_err_o), 64'h0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3_overrun",      64'(bus_a.overrun_err_o), 64'h1);
    checkOutput("t3_words_kept",   64'(bus_a.words_o),       64'h00FF_F0F0_0F0F);
    checkOutput("t3_led",          64'(bus_a.led_o),         64'h5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t3_overrun_sticky", 64'(bus_a.overrun_err_o), 64'h1);

    // Test 4: reset in the middle of a frame.
    sendWordA(16'h1111, 16);
    sendWordA(16'h2222, 14);
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkResetA("t4_reset");
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    sendFrameA(16'h1111, 16'h2222, 16'h3333);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t4_words", 64'(bus_a.words_o),     64'h3333_2222_1111);
    checkOutput("t4_cnt",   64'(bus_a.frame_cnt_o), 64'h1);

    // Test 5: LSB-first, 8-bit words, two per frame.
    sendWordB(8'h81);
    sendWordB(8'h7E);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t5_words", 64'(bus_b.words_o),       64'h7E81);
    checkOutput("t5_led",   64'(bus_b.led_o),         64'h2);
    checkOutput("t5_cnt",   64'(bus_b.frame_cnt_o),   64'h1);
    checkOutput("t5_valid", 64'(bus_b.frame_valid_o), 64'h1);

    // Test 6: 256 frames wrap the counter.
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sendFrameA(16'(i), ~16'(i), 16'h4000);
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (i == 254) checkOutput("t6_cnt_255", 64'(bus_a.frame_cnt_o), 64'd255);
    end
    checkOutput("t6_cnt_wrap", 64'(bus_a.frame_cnt_o),   64'h0);
    checkOutput("t6_valid",    64'(bus_a.frame_valid_o), 64'h1);
    checkOutput("t6_words",    64'(bus_a.words_o),       64'h4000_FF00_00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
